sn76489_bus_if: RTL and testbench
=================================

# sn76489_bus_if

CPU-side write interface and clock prescaler for the SN76489 sound core. It samples CPU write strobes and buffers the written bytes. It tracks the latched channel/register selection and drives the per-channel write enables, data and register-type select into the three tone stages and the noise stage. Delivery is aligned to the divided chip clock enable it generates, so a downstream stage sees each write in the one cycle where its `clk_en_i && we_i` is true.

## Interface
Parameters:
- DIVIDER, 16: number of `clk_en_i` pulses per `clk_en_o` pulse; legal range 2–16.
- FIFO_DEPTH, 4: write buffer depth. Only used with SN76489_WRITE_FIFO_EN; must be a power of 2, minimum 2.

Ports:
- clock_i, input, 1: system clock. All logic is single-clock.
- res_i, input, 1: reset, synchronous, active-high.
- clk_en_i, input, 1: master chip clock enable (e.g. 3.58 MHz rate).
- ce_n_i, input, 1: chip enable, active-low. Synchronous to clock_i.
- we_n_i, input, 1: write enable, active-low. Synchronous to clock_i.
- d_i, input, [0:7]: CPU data. Bit 0 is the MSB.
- ready_o, input/output: output, 1: CPU ready. Low means the CPU must stall.
- overrun_o, output, 1: sticky flag, set when a write is dropped.
- clk_en_o, output, 1: divided enable to the tone and noise stages.
- d_o, output, [0:7]: write data to the tone and noise stages.
- r2_o, output, 1: register type. 0 = frequency/control, 1 = attenuator.
- tone_we_o, output, [0:2]: write enables for tone channels 0–2.
- noise_we_o, output, 1: write enable for the noise channel.

## Operation
- Prescaler:
  - 4-bit counter advances on each `clk_en_i`.
  - When the counter equals DIVIDER-1 and `clk_en_i` is high, `clk_en_o` = 1 for exactly one clock and the counter wraps to 0.
- Strobe detect:
  - `strb = ~ce_n_i & ~we_n_i`, registered as `strb_q`.
  - A write is accepted in a cycle where `strb & ~strb_q` is true; `d_i` is captured in that same cycle.
  - A held strobe produces exactly one write. The strobe must drop before another write is accepted.
- Delivery: a buffered byte B is popped in a cycle where `clk_en_o` = 1 and the buffer is non-empty. In that cycle:
  - If `B[0]` = 1 (latch byte): the latched channel is set to `B[1:2]` and latched r2 to `B[3]`, and those new values are used for this same delivery.
  - If `B[0]` = 0 (data byte): the current latched channel and latched r2 are used.
  - Channel decode: 00 → `tone_we_o[0]`, 01 → `tone_we_o[1]`, 10 → `tone_we_o[2]`, 11 → `noise_we_o`.
  - Exactly one write enable is driven high, for one clock. `d_o` = B and `r2_o` = latched r2.
  - `d_o` and `r2_o` hold their values until the next delivery.
- At most one byte is delivered per `clk_en_o` pulse.
- Overrun: a write accepted while the buffer is full is dropped and sets `overrun_o`. `overrun_o` clears only on reset.
- Reset values:
  - Outputs: `ready_o` = 1, `overrun_o` = 0, `clk_en_o` = 0, all write enables 0, `d_o` = 0, `r2_o` = 0.
  - Internal: prescaler = 0, buffer empty, latched channel = 00, latched r2 = 0.
- Reset asserted mid-operation discards every buffered write. No write enable pulses in the reset cycle or the cycle after it.

## Timing
- Accept cycle T → the byte is occupancy-visible at T+1.
- Delivery happens at the first `clk_en_o` pulse at cycle ≥ T+1. Worst-case latency is DIVIDER × (`clk_en_i` period) + 1 clocks.
- Push and pop in the same cycle are both honoured; occupancy is unchanged.
- `ready_o` is registered. It goes low in the cycle after a push that makes the buffer full, and returns high in the cycle after the pop that makes it non-full.

## Configuration
- Macro: `SN76489_WRITE_FIFO_EN`.
- Defined: the buffer is a FIFO_DEPTH-entry FIFO. `ready_o` falls only when the FIFO is full, so back-to-back writes proceed without stalling up to FIFO_DEPTH.
- Undefined:
  - The buffer is a single entry and FIFO_DEPTH is ignored.
  - `ready_o` is low from T+1 through the delivery cycle and high the cycle after delivery. This matches the real chip's write wait behaviour.
  - A strobe accepted while the entry is pending is dropped and sets `overrun_o`.

## Test plan
- Reset, then run `clk_en_i` continuously with DIVIDER = 16 → `clk_en_o` pulses every 16th enable; all outputs hold their reset values until the first write.
- Write 0x8A, then after `ready_o` is high write 0x1F → 0x8A is delivered on `tone_we_o[0]` with `r2_o` = 0; 0x1F is delivered next on `tone_we_o[0]` with `r2_o` = 0.
- Write 0xF3, then 0x05 → both are delivered on `noise_we_o`, with `r2_o` = 1 for both.
- Without the macro, write 0xB0 → `ready_o` = 0 from T+1 until the `clk_en_o` delivery cycle and 1 the cycle after; `tone_we_o[1]` pulses with `d_o` = 0xB0 and `r2_o` = 1. A second strobe during this wait sets `overrun_o` = 1.
- With the macro and FIFO_DEPTH = 4, issue five writes within one `clk_en_o` period → `ready_o` falls after the 4th; the 5th is dropped and `overrun_o` = 1; four deliveries follow on four consecutive `clk_en_o` pulses.
- Assert `res_i` with 3 bytes buffered → no further write enables pulse; `ready_o` = 1 and `overrun_o` = 0 after reset.

Source files
------------

// File: rtl/sn76489_bus_if.sv
// sn76489_bus_if
//
// CPU-side write interface and chip clock prescaler for the SN76489 sound
// core. CPU write strobes are edge-detected and the written bytes buffered.
// Each buffered byte is handed to the tone/noise stages in a cycle where the
// divided enable clk_en_o is high. A downstream stage therefore sees the write
// in the one cycle where its own clk_en_i && we_i is true.
//
// Configuration macro: SN76489_WRITE_FIFO_EN
//   defined   : FIFO_DEPTH-entry write FIFO; ready_o drops only when full.
//   undefined : single-entry buffer; ready_o stays low while a byte is
//               pending, which mimics the real chip's write wait.
//
// Parameters
//   DIVIDER    : clk_en_i pulses per clk_en_o pulse (2..16)
//   FIFO_DEPTH : FIFO entries when SN76489_WRITE_FIFO_EN is defined
//                (power of 2, >= 2)
//
// Ports
//   clock_i    : system clock
//   res_i      : synchronous active-high reset
//   clk_en_i   : master chip clock enable
//   ce_n_i     : chip enable, active-low
//   we_n_i     : write enable, active-low
//   d_i        : CPU data, bit 0 is the MSB
//   ready_o    : CPU ready, low = stall
//   overrun_o  : sticky, set when a write is dropped
//   clk_en_o   : divided enable to the tone and noise stages
//   d_o        : write data to the stages
//   r2_o       : register type, 0 = frequency/control, 1 = attenuator
//   tone_we_o  : write enables for tone channels 0..2
//   noise_we_o : write enable for the noise channel

module sn76489_bus_if #(
    parameter int DIVIDER    = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock_i,
    input  logic       res_i,
    input  logic       clk_en_i,
    input  logic       ce_n_i,
    input  logic       we_n_i,
    input  logic [0:7] d_i,
    output logic       ready_o,
    output logic       overrun_o,
    output logic       clk_en_o,
    output logic [0:7] d_o,
    output logic       r2_o,
    output logic [0:2] tone_we_o,
    output logic       noise_we_o
);

    localparam logic [3:0] CNT_LAST = 4'(DIVIDER - 1);

    // Elaboration-time guard against unsupported parameter values.
    if (DIVIDER < 2 || DIVIDER > 16 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_param_check
        $error("sn76489_bus_if: illegal DIVIDER or FIFO_DEPTH");
    end

    logic [3:0] cnt_q, cnt_d;
    logic       strb_q, strb_d;
    logic       ready_q, ready_d;
    logic       overrun_q, overrun_d;
    logic [0:1] ch_q, ch_d;
    logic       r2_q, r2_d;
    logic [0:7] dout_q, dout_d;

    logic       strb;
    logic       accept;
    logic       push;
    logic       pop;
    logic       buf_full;
    logic       buf_empty;
    logic       buf_ready_d;
    logic [0:7] head;
    logic [0:1] sel_ch;
    logic       sel_r2;

    // A write is taken only on the rising edge of the combined strobe, so a
    // held strobe yields a single write.
    assign strb   = ~ce_n_i & ~we_n_i;
    assign accept = strb & ~strb_q;
    assign push   = accept & ~buf_full;

    // The enable is combinational so a byte pushed at T can ride a pulse at T+1.
    // Gating with reset keeps every write enable quiet in the reset cycle.
    assign clk_en_o = clk_en_i & (cnt_q == CNT_LAST) & ~res_i;
    assign pop      = clk_en_o & ~buf_empty;

`ifdef SN76489_WRITE_FIFO_EN
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int OCC_W = AW + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    logic [0:7]       mem_q [FIFO_DEPTH];
    logic [0:7]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_q, wr_d;
    logic [AW-1:0]    rd_q, rd_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    assign buf_full  = (occ_q == OCC_FULL);
    assign buf_empty = (occ_q == '0);
    assign head      = mem_q[rd_q];

    // Circular buffer; pointers wrap naturally because the depth is a power of 2.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        occ_d = occ_q;
        if (push) begin
            mem_d[wr_q] = d_i;
            wr_d        = wr_q + AW'(1);
        end
        if (pop) begin
            rd_d = rd_q + AW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_W'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_W'(1);
        end
    end

    assign buf_ready_d = (occ_d != OCC_FULL);

    always_ff @(posedge clock_i) begin
        if (res_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            occ_q <= occ_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clock_i) begin
        mem_q <= mem_d;
    end
`else
    logic       valid_q, valid_d;
    logic [0:7] data_q, data_d;

    assign buf_full  = valid_q;
    assign buf_empty = ~valid_q;
    assign head      = data_q;

    always_comb begin
        valid_d = push | (valid_q & ~pop);
        data_d  = push ? d_i : data_q;
    end

    // Ready tracks the pending flag, holding the CPU off until delivery.
    assign buf_ready_d = ~valid_d;

    always_ff @(posedge clock_i) begin
        if (res_i) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
`endif

    // Prescaler, strobe history, latch state and delivery decode. A latch byte
    // updates channel/r2 and is itself delivered with the new selection.
    always_comb begin
        cnt_d = cnt_q;
        if (clk_en_i) begin
            cnt_d = (cnt_q == CNT_LAST) ? 4'd0 : cnt_q + 4'd1;
        end
        strb_d     = strb;
        overrun_d  = overrun_q | (accept & buf_full);
        ready_d    = buf_ready_d;
        sel_ch     = head[0] ? head[1:2] : ch_q;
        sel_r2     = head[0] ? head[3] : r2_q;
        ch_d       = ch_q;
        r2_d       = r2_q;
        dout_d     = dout_q;
        tone_we_o  = '0;
        noise_we_o = 1'b0;
        if (pop) begin
            ch_d   = sel_ch;
            r2_d   = sel_r2;
            dout_d = head;
            case (sel_ch)
                2'd0:    tone_we_o[0] = 1'b1;
                2'd1:    tone_we_o[1] = 1'b1;
                2'd2:    tone_we_o[2] = 1'b1;
                default: noise_we_o   = 1'b1;
            endcase
        end
    end

    // Data and r2 show the delivered values in the delivery cycle itself and
    // hold them afterwards.
    assign d_o       = dout_d;
    assign r2_o      = r2_d;
    assign ready_o   = ready_q;
    assign overrun_o = overrun_q;

    always_ff @(posedge clock_i) begin
        if (res_i) begin
            cnt_q     <= '0;
            strb_q    <= 1'b0;
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
            ch_q      <= '0;
            r2_q      <= 1'b0;
            dout_q    <= '0;
        end else begin
            cnt_q     <= cnt_d;
            strb_q    <= strb_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
            ch_q      <= ch_d;
            r2_q      <= r2_d;
            dout_q    <= dout_d;
        end
    end

endmodule

// File: tb/tb_sn76489_bus_if.sv
// tb_sn76489_bus_if
//
// Directed bench for sn76489_bus_if with default parameters (DIVIDER = 16,
// FIFO_DEPTH = 4). Expected deliveries are queued when a write is driven and
// compared when a write enable pulses. A monitor also models the prescaler so
// every clk_en_o pulse is predicted. SN76489_WRITE_FIFO_EN selects the
// matching buffer scenario.

module tb_sn76489_bus_if;

    logic       clock_i;
    logic       res_i;
    logic       clk_en_i;
    logic       ce_n_i;
    logic       we_n_i;
    logic [0:7] d_i;
    logic       ready_o;
    logic       overrun_o;
    logic       clk_en_o;
    logic [0:7] d_o;
    logic       r2_o;
    logic [0:2] tone_we_o;
    logic       noise_we_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] d;
        logic [3:0] we;
        logic       r2;
    } exp_t;

    exp_t exp_q[$];

    logic [1:0]  m_ch = 2'd0;
    logic        m_r2 = 1'b0;
    int unsigned mdl_cnt = 0;

`ifdef SN76489_WRITE_FIFO_EN
    localparam logic READY_WHILE_PENDING = 1'b1;
`else
    localparam logic READY_WHILE_PENDING = 1'b0;
`endif

    sn76489_bus_if #(
        .DIVIDER    (16),
        .FIFO_DEPTH (4)
    ) dut (
        .clock_i    (clock_i),
        .res_i      (res_i),
        .clk_en_i   (clk_en_i),
        .ce_n_i     (ce_n_i),
        .we_n_i     (we_n_i),
        .d_i        (d_i),
        .ready_o    (ready_o),
        .overrun_o  (overrun_o),
        .clk_en_o   (clk_en_o),
        .d_o        (d_o),
        .r2_o       (r2_o),
        .tone_we_o  (tone_we_o),
        .noise_we_o (noise_we_o)
    );

    // 10 ns system clock.
    initial begin
        clock_i = 1'b0;
        forever #5 clock_i = ~clock_i;
    end

    // Master chip enable runs continuously at half the system clock rate.
    initial begin
        clk_en_i = 1'b0;
        forever begin
            @(posedge clock_i);
            #1;
            clk_en_i = ~clk_en_i;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one strobe for 'hold' cycles; accepted writes are queued with the
    // channel and r2 the model expects them to be delivered with.
    task automatic applyStimulus(input logic [7:0] b, input bit accept, input int hold);
        @(posedge clock_i);
        #1;
        ce_n_i = 1'b0;
        we_n_i = 1'b0;
        d_i    = b;
        if (accept) begin
            if (b[7]) begin
                m_ch = b[6:5];
                m_r2 = b[4];
            end
            exp_q.push_back('{d: b, we: 4'b1000 >> m_ch, r2: m_r2});
        end
        repeat (hold) @(posedge clock_i);
        #1;
        ce_n_i = 1'b1;
        we_n_i = 1'b1;
    endtask

    task automatic waitPulse();
        int n = 0;
        do begin
            @(negedge clock_i);
            n++;
        end while (clk_en_o !== 1'b1 && n < 100);
        checkOutput("pulse_timeout", clk_en_o, 1);
    endtask

    task automatic waitDelivered(input logic [7:0] last);
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock_i);
            #1;
            n++;
        end
        checkOutput("deliver_timeout", exp_q.size(), 0);
        checkOutput("ready_in_delivery", ready_o, READY_WHILE_PENDING);
        @(negedge clock_i);
        checkOutput("ready_after_delivery", ready_o, 1);
        checkOutput("d_o_hold", d_o, last);
        checkOutput("r2_o_hold", r2_o, m_r2);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"}, ready_o, 1);
        checkOutput({tag, "_overrun"}, overrun_o, 0);
        checkOutput({tag, "_clk_en"}, clk_en_o, 0);
        checkOutput({tag, "_we"}, {tone_we_o, noise_we_o}, 0);
        checkOutput({tag, "_d_o"}, d_o, 0);
        checkOutput({tag, "_r2_o"}, r2_o, 0);
    endtask

    // Monitor: predicts every clk_en_o and scores each write enable pulse
    // against the head of the expectation queue.
    always @(negedge clock_i) begin
        logic exp_ce;
        exp_t e;
        exp_ce = !res_i && clk_en_i && (mdl_cnt == 15);
        checkOutput("clk_en_o", clk_en_o, exp_ce);
        if (res_i) begin
            mdl_cnt = 0;
        end else if (clk_en_i) begin
            mdl_cnt = (mdl_cnt == 15) ? 0 : mdl_cnt + 1;
        end
        if ((|tone_we_o) || noise_we_o) begin
            if (exp_q.size() == 0) begin
                checkOutput("spurious_we", {tone_we_o, noise_we_o}, 0);
            end else begin
                e = exp_q.pop_front();
                checkOutput("we_select", {tone_we_o, noise_we_o}, e.we);
                checkOutput("d_o", d_o, e.d);
                checkOutput("r2_o", r2_o, e.r2);
                checkOutput("we_with_clk_en", clk_en_o, 1);
            end
        end
    end

    initial begin
        res_i  = 1'b1;
        ce_n_i = 1'b1;
        we_n_i = 1'b1;
        d_i    = '0;
        repeat (3) @(posedge clock_i);
        #1;
        res_i = 1'b0;
        @(negedge clock_i);
        checkResetState("reset");

        // Idle: the monitor checks the clk_en_o cadence and that nothing pulses.
        repeat (40) @(negedge clock_i);
        checkResetState("idle");

        $display("[TB] latch 0x8A then data 0x1F on tone 0");
        applyStimulus(8'h8A, 1'b1, 1);
        @(negedge clock_i);
        checkOutput("ready_after_push", ready_o, READY_WHILE_PENDING);
        waitDelivered(8'h8A);
        applyStimulus(8'h1F, 1'b1, 3);
        waitDelivered(8'h1F);
        checkOutput("no_overrun_on_held_strobe", overrun_o, 0);

        $display("[TB] latch 0xF3 then data 0x05 on noise");
        applyStimulus(8'hF3, 1'b1, 1);
        waitDelivered(8'hF3);
        applyStimulus(8'h05, 1'b1, 1);
        waitDelivered(8'h05);

`ifdef SN76489_WRITE_FIFO_EN
        $display("[TB] five writes within one clk_en_o period");
        waitPulse();
        applyStimulus(8'h9F, 1'b1, 1);
        applyStimulus(8'h01, 1'b1, 1);
        applyStimulus(8'hC5, 1'b1, 1);
        @(negedge clock_i);
        checkOutput("ready_before_full", ready_o, 1);
        applyStimulus(8'h07, 1'b1, 1);
        @(negedge clock_i);
        checkOutput("ready_when_full", ready_o, 0);
        checkOutput("overrun_before_drop", overrun_o, 0);
        applyStimulus(8'h33, 1'b0, 1);
        @(negedge clock_i);
        checkOutput("overrun_after_drop", overrun_o, 1);
        waitDelivered(8'h07);
`else
        $display("[TB] latch 0xB0 with a second strobe during the wait");
        waitPulse();
        applyStimulus(8'hB0, 1'b1, 1);
        @(negedge clock_i);
        checkOutput("ready_low_pending", ready_o, 0);
        checkOutput("overrun_before_drop", overrun_o, 0);
        applyStimulus(8'h42, 1'b0, 1);
        @(negedge clock_i);
        checkOutput("overrun_after_drop", overrun_o, 1);
        checkOutput("ready_still_low", ready_o, 0);
        waitDelivered(8'hB0);
`endif

        $display("[TB] reset with writes buffered");
        waitPulse();
        applyStimulus(8'hE0, 1'b1, 1);
`ifdef SN76489_WRITE_FIFO_EN
        applyStimulus(8'h12, 1'b1, 1);
        applyStimulus(8'h34, 1'b1, 1);
`endif
        @(posedge clock_i);
        #1;
        res_i = 1'b1;
        exp_q.delete();
        m_ch = 2'd0;
        m_r2 = 1'b0;
        repeat (2) @(posedge clock_i);
        #1;
        res_i = 1'b0;
        @(negedge clock_i);
        checkResetState("post_reset");
        repeat (80) @(negedge clock_i);
        checkOutput("post_reset_overrun", overrun_o, 0);

        // A data byte right after reset must use the reset latch (tone 0, r2 0).
        applyStimulus(8'h1F, 1'b1, 1);
        waitDelivered(8'h1F);

        repeat (5) @(negedge clock_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
